// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch queue.
package fetch_pkg;

    localparam int          PC_STEP      = 4;
    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // One queued fetch result: the word and the address it was read from.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with push/pop/flush; head is readable combinationally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [W-1:0]                 i_data,
    output logic [W-1:0]                 o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush && !srst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues IMem reads, buffers returns, redirects on PCSrc.
// Optional same-cycle bypass of returning data when the queue is empty: FETCH_BYPASS_EN.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter int               ADDR_W   = DEF_ADDR_W,
    parameter int               DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] Result,
    output logic              IMem_Req,
    output logic [ADDR_W-1:0] IMem_Addr,
    input  logic [DATA_W-1:0] IMem_RData,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] Instr_PC,
    output logic              Instr_Valid,
    input  logic              Instr_Ready
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_pending_valid;
    logic [ADDR_W-1:0] r_pending_pc;

    logic [ENT_W-1:0]  w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_credit;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;

    // Outstanding reads count against capacity; a same-cycle pop does not free a slot.
    assign w_credit  = ({1'b0, w_count} + (CNT_W+1)'(r_pending_valid)) < (CNT_W+1)'(DEPTH);
    assign IMem_Req  = !Reset && !PCSrc && w_credit;
    assign IMem_Addr = r_fetch_pc;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_empty && r_pending_valid && !PCSrc && !Reset;
`else
    assign w_bypass = 1'b0;
`endif

    assign Instr_Valid = !Reset && !PCSrc && (!w_empty || w_bypass);
    assign Instr       = w_bypass ? IMem_RData   : w_head[DATA_W-1:0];
    assign Instr_PC    = w_bypass ? r_pending_pc : w_head[ENT_W-1:DATA_W];

    assign w_pop  = !w_bypass && Instr_Valid && Instr_Ready;
    assign w_push = r_pending_valid && !PCSrc && !Reset && !(w_bypass && Instr_Ready);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_fetch_pc      <= RESET_PC;
            r_pending_valid <= 1'b0;
            r_pending_pc    <= '0;
        end else if (PCSrc) begin
            r_fetch_pc      <= {Result[ADDR_W-1:2], 2'b00};
            r_pending_valid <= 1'b0;
        end else if (IMem_Req) begin
            r_fetch_pc      <= r_fetch_pc + ADDR_W'(PC_STEP);
            r_pending_valid <= 1'b1;
            r_pending_pc    <= r_fetch_pc;
        end else begin
            r_pending_valid <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (CLK),
        .srst    (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (PCSrc),
        .i_data  ({r_pending_pc, IMem_RData}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // The credit rule must make a push into a full queue impossible.
    a_no_push_when_full: assert property (@(posedge CLK) disable iff (Reset) !(w_push && w_full));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (two instances: RESET_PC 0 and 0xFFFFFFF8).
module tb_instr_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        CLK;
    logic        Reset;
    logic        PCSrc;
    logic [31:0] Result;
    logic        Instr_Ready;

    logic        req_a, valid_a, req_b, valid_b;
    logic [31:0] addr_a, rdata_a, instr_a, pc_a;
    logic [31:0] addr_b, rdata_b, instr_b, pc_b;

    int total = 0;
    int bad   = 0;

    instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut_a (
        .CLK(CLK), .Reset(Reset), .PCSrc(PCSrc), .Result(Result),
        .IMem_Req(req_a), .IMem_Addr(addr_a), .IMem_RData(rdata_a),
        .Instr(instr_a), .Instr_PC(pc_a), .Instr_Valid(valid_a), .Instr_Ready(Instr_Ready)
    );

    instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .CLK(CLK), .Reset(Reset), .PCSrc(PCSrc), .Result(Result),
        .IMem_Req(req_b), .IMem_Addr(addr_b), .IMem_RData(rdata_b),
        .Instr(instr_b), .Instr_PC(pc_b), .Instr_Valid(valid_b), .Instr_Ready(Instr_Ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory model: 1-cycle read latency, mem[a] = a ^ 0xA5A50000.
    always @(posedge CLK) begin
        if (req_a) rdata_a <= addr_a ^ 32'hA5A5_0000;
        if (req_b) rdata_b <= addr_b ^ 32'hA5A5_0000;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the next delivery from dut_a and check it; the pop happens at the next edge.
    task automatic expect_next(input string tag, input logic [31:0] exp_pc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (valid_a === 1'b1) begin
                chk({tag, "_pc"}, pc_a, exp_pc);
                chk({tag, "_instr"}, instr_a, exp_pc ^ 32'hA5A5_0000);
                seen = 1'b1;
            end
            tick();
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int issues;
        logic [31:0] e;

        // ---- reset held 5 cycles, streaming with Ready=1 ----
        Reset = 1'b1; PCSrc = 1'b0; Result = '0; Instr_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_req", {31'd0, req_a}, 32'd0);
            chk("rst_valid", {31'd0, valid_a}, 32'd0);
        end
        Reset = 1'b0;
        #1;
        chk("c0_req", {31'd0, req_a}, 32'd1);
        chk("c0_addr", addr_a, 32'h0);
        chk("c0_valid", {31'd0, valid_a}, 32'd0);
        chk("c0_addr_b", addr_b, 32'hFFFF_FFF8);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            chk("stream_valid", {31'd0, valid_a}, (cyc >= LAT) ? 32'd1 : 32'd0);
            chk("stream_valid_b", {31'd0, valid_b}, (cyc >= LAT) ? 32'd1 : 32'd0);
            if (cyc >= LAT) begin
                e = 32'(4 * (cyc - LAT));
                chk("stream_pc", pc_a, e);
                chk("stream_instr", instr_a, e ^ 32'hA5A5_0000);
                e = 32'hFFFF_FFF8 + 32'(4 * (cyc - LAT));
                chk("wrap_pc", pc_b, e);
                chk("wrap_instr", instr_b, e ^ 32'hA5A5_0000);
            end
        end

        // ---- backpressure from the start ----
        Reset = 1'b1; Instr_Ready = 1'b0;
        tick();
        Reset = 1'b0;
        #1;
        issues = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_a === 1'b1) issues++;
            tick();
        end
        chk("bp_issues", 32'(issues), 32'd4);
        chk("bp_req_stopped", {31'd0, req_a}, 32'd0);
        chk("bp_head_valid", {31'd0, valid_a}, 32'd1);
        chk("bp_head_pc", pc_a, 32'h0);
        Instr_Ready = 1'b1;
        #1;
        expect_next("bp_d0", 32'h00);
        expect_next("bp_d1", 32'h04);
        expect_next("bp_d2", 32'h08);
        expect_next("bp_d3", 32'h0C);
        expect_next("bp_d4", 32'h10);
        expect_next("bp_d5", 32'h14);

        // ---- full queue, then redirect to 0x103 ----
        Instr_Ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("full_req", {31'd0, req_a}, 32'd0);
        PCSrc = 1'b1; Result = 32'h103;
        #1;
        chk("redir_valid", {31'd0, valid_a}, 32'd0);
        chk("redir_req", {31'd0, req_a}, 32'd0);
        tick();
        PCSrc = 1'b0; Instr_Ready = 1'b1;
        #1;
        chk("redir_r1_req", {31'd0, req_a}, 32'd1);
        chk("redir_r1_addr", addr_a, 32'h100);
        chk("redir_r1_valid", {31'd0, valid_a}, 32'd0);
        tick();
        chk("redir_r2_valid", {31'd0, valid_a}, (LAT == 1) ? 32'd1 : 32'd0);
        expect_next("redir_d0", 32'h100);
        expect_next("redir_d1", 32'h104);

        // ---- 1-cycle reset with 3 queued entries and a read pending ----
        Reset = 1'b1; Instr_Ready = 1'b0;
        tick();
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_valid_pre", {31'd0, valid_a}, 32'd1);
        chk("mid_credit_req", {31'd0, req_a}, 32'd0);
        Reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, valid_a}, 32'd0);
        chk("mid_rst_req", {31'd0, req_a}, 32'd0);
        tick();
        Reset = 1'b0;
        #1;
        chk("mid_after_valid", {31'd0, valid_a}, 32'd0);
        chk("mid_after_req", {31'd0, req_a}, 32'd1);
        chk("mid_after_addr", addr_a, 32'h0);
        Instr_Ready = 1'b1;
        #1;
        expect_next("mid_d0", 32'h0);
        expect_next("mid_d1", 32'h4);
        expect_next("mid_d2", 32'h8);

        // ---- back-to-back redirects: 0x40 then 0x80 ----
        PCSrc = 1'b1; Result = 32'h40;
        #1;
        chk("b2b_r0_req", {31'd0, req_a}, 32'd0);
        tick();
        Result = 32'h80;
        #1;
        chk("b2b_r1_req", {31'd0, req_a}, 32'd0);
        chk("b2b_r1_valid", {31'd0, valid_a}, 32'd0);
        tick();
        PCSrc = 1'b0;
        #1;
        chk("b2b_req", {31'd0, req_a}, 32'd1);
        chk("b2b_addr", addr_a, 32'h80);
        expect_next("b2b_d0", 32'h80);
        expect_next("b2b_d1", 32'h84);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Consumer end of the program-counter interface: takes the PCSrc/Result redirect pair, issues instruction-memory reads, and buffers returned words for the decoder.
- Sits between instruction memory (synchronous, 1-cycle read latency) and the decode stage.
- Delivers instructions through a valid/ready handshake.
- On a taken branch it flushes everything in flight and restarts fetch at the target.

Parameters:
- DEPTH, 4, instruction queue entries (power of 2, >= 2)
- RESET_PC, 32'h00000000, first fetch address after reset
- ADDR_W, 32, address / PC width
- DATA_W, 32, instruction width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- PCSrc  in  1  redirect request; 1 = taken branch / PC write
- Result  in  ADDR_W  redirect target, sampled when PCSrc=1
- IMem_Req  out  1  read strobe to instruction memory
- IMem_Addr  out  ADDR_W  word-aligned read address
- IMem_RData  in  DATA_W  read data, valid the cycle after IMem_Req
- Instr  out  DATA_W  instruction at queue head
- Instr_PC  out  ADDR_W  address of Instr
- Instr_Valid  out  1  head entry valid
- Instr_Ready  in  1  decoder accepts head this cycle

Behaviour:
- State: fetch_pc, pending_valid, pending_pc, FIFO of {pc, instr}, count (0..DEPTH).
- Reset (Reset=1 at edge):
  - fetch_pc=RESET_PC; pending_valid=0; count=0.
  - During the Reset cycle, IMem_Req=0 and Instr_Valid=0.
  - Reset overrides PCSrc and any in-flight transfer. Mid-operation reset discards all queued and pending data.
- Issue:
  - IMem_Req=1 when !Reset && !PCSrc && (count + pending_valid) < DEPTH. Pops in the same cycle are not credited.
  - IMem_Addr=fetch_pc always.
  - On issue: fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x0). Also pending_valid <= 1 and pending_pc <= fetch_pc. Otherwise pending_valid <= 0.
- Return: when pending_valid=1, IMem_RData belongs to pending_pc. It is pushed into the FIFO at the end of that cycle unless bypassed (see optional feature) or PCSrc=1.
- Output:
  - Instr_Valid = (count != 0) && !PCSrc.
  - Instr/Instr_PC come from the FIFO head.
  - Pop on Instr_Valid && Instr_Ready.
  - Simultaneous push and pop are allowed; count is unchanged.
  - Push never occurs when full; the credit rule guarantees this. This is an assertion target.
- Latency: request in cycle N -> Instr_Valid in cycle N+2; the first valid instruction appears 2 cycles after Reset falls.
- Redirect (PCSrc=1 in cycle R):
  - IMem_Req=0, Instr_Valid=0, pop ignored.
  - FIFO cleared; the pending return in R is dropped.
  - fetch_pc <= {Result[ADDR_W-1:2], 2'b00}, so low bits are ignored.
  - Target requested in R+1 and valid at R+3.
  - Back-to-back PCSrc: the last target wins.
- Instr_Ready while Instr_Valid=0 has no effect.

Optional Feature:
- FETCH_BYPASS_EN defined: when count==0 and pending_valid=1 (no PCSrc), Instr_Valid=1 with Instr=IMem_RData and Instr_PC=pending_pc in the same cycle.
  - If Instr_Ready, the word is consumed and not pushed; otherwise it is pushed.
  - Latency becomes 1 cycle from request; the first instruction appears 1 cycle after Reset falls.
- Undefined: no bypass; all data passes through the FIFO; 2-cycle latency.

Decomposition:
- Package fetch_pkg:
  - PC_STEP=4
  - default RESET_PC
  - ADDR_W/DATA_W defaults
  - entry struct type {pc, instr}
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO with push/pop/flush, count, and full/empty outputs.
- The top level holds fetch_pc, the pending register, credit logic, and the bypass mux.

Test Plan:
- Reset held 5 cycles, then Instr_Ready=1 and IMem returns mem[a]=a^32'hA5A50000. Required: Instr_PC = 0x0, 0x4, 0x8, ... on consecutive cycles from 2 cycles after Reset falls (1 with FETCH_BYPASS_EN), and Instr matches.
- Backpressure with Instr_Ready=0 from the start. Required: IMem_Req stops after 4 issues; queue holds 0x0, 0x4, 0x8, 0xC. Then with Ready=1: those four drain in order, then 0x10 follows with no duplicate or missing PC.
- Full queue plus PCSrc=1 with Result=0x103. Required: Instr_Valid=0 in the redirect cycle; IMem_Addr=0x100 with Req=1 next cycle; the next delivered Instr_PC sequence is 0x100, 0x104; old entries never appear.
- RESET_PC=32'hFFFFFFF8. Required: delivered PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset asserted for 1 cycle while the queue holds 3 entries and a read is pending. Required: Instr_Valid=0 next cycle; the fetch sequence restarts at RESET_PC; no stale data.
- PCSrc asserted 2 consecutive cycles (Result=0x40, then 0x80). Required: only 0x80 is requested; first delivered PC is 0x80.
